pci_bus_arbiter: RTL

Central arbiter for the shared PCI-style bus used by the `device` instances. It takes each device's active-low `request`, drives one active-low `grant` per device and monitors `iframe`/`iready` to detect when the bus is busy or idle. It provides round-robin fairness, a start timeout for a granted master that never drives the bus, and a tenure limit so a master holding the bus can be preempted.

---
 rtl/pci_bus_arbiter_if.sv | 25 ++
 rtl/pci_bus_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/pci_bus_arbiter_if.sv
// Request/grant and observed bus signals shared by the arbiter and the devices.
// The slave view belongs to the arbiter; the master view belongs to the devices.
interface pci_bus_arbiter_if #(
    parameter int N_MASTERS = 4
);
    localparam int OW = $clog2(N_MASTERS);

    logic [N_MASTERS-1:0] req;
    logic                 iframe;
    logic                 iready;
    logic [N_MASTERS-1:0] gnt;
    logic [OW-1:0]        owner;
    logic                 bus_busy;
    logic                 timeout_pulse;

    modport master (
        output req, iframe, iready,
        input  gnt, owner, bus_busy, timeout_pulse
    );

    modport slave (
        input  req, iframe, iready,
        output gnt, owner, bus_busy, timeout_pulse
    );
endinterface

// File: rtl/pci_bus_arbiter.sv
// Round-robin PCI-style bus arbiter with a start timeout for idle grantees
// and a tenure limit that preempts a long-running owner when others wait.
module pci_bus_arbiter #(
    parameter int N_MASTERS     = 4,
    parameter int START_TIMEOUT = 16,
    parameter int MAX_TENURE    = 32
) (
    input  logic               clk,
    input  logic               rst,
    pci_bus_arbiter_if.slave   bus
);
    localparam int OW = $clog2(N_MASTERS);
    localparam int SW = $clog2(START_TIMEOUT + 1);
    localparam int TW = $clog2(MAX_TENURE + 1);

    typedef enum logic [1:0] {IDLE, GRANT, BUSY, RELEASE} state_t;

    state_t               state, state_next;
    logic [N_MASTERS-1:0] gnt, gnt_next;
    logic [OW-1:0]        owner, owner_next;
    logic [OW-1:0]        rr_ptr, rr_ptr_next;
    logic [SW-1:0]        start_cnt, start_cnt_next;
    logic [TW-1:0]        tenure_cnt, tenure_cnt_next;
    logic                 timeout_pulse, timeout_pulse_next;

    logic                 bus_idle;
    logic                 owner_req;
    logic                 other_req;
    logic [N_MASTERS-1:0] owner_mask;
    logic [N_MASTERS-1:0] pick_mask;
    logic                 pick_found;
    logic [OW-1:0]        pick_idx;
    logic [OW-1:0]        scan_idx;

    // Increment modulo N_MASTERS, correct for non-power-of-two counts.
    function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] v);
        if (v == OW'(N_MASTERS - 1)) begin
            return '0;
        end
        return v + 1'b1;
    endfunction

    assign bus_idle   = bus.iframe & bus.iready;
    assign owner_mask = {{(N_MASTERS-1){1'b0}}, 1'b1} << owner;
    assign owner_req  = ~bus.req[owner];
    assign other_req  = |(~bus.req & ~owner_mask);
    assign pick_mask  = {{(N_MASTERS-1){1'b0}}, 1'b1} << pick_idx;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_ptr;
        scan_idx   = rr_ptr;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (!pick_found && !bus.req[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
            scan_idx = wrap_inc(scan_idx);
        end
    end

    always_comb begin
        state_next         = state;
        gnt_next           = gnt;
        owner_next         = owner;
        rr_ptr_next        = rr_ptr;
        start_cnt_next     = start_cnt;
        tenure_cnt_next    = tenure_cnt;
        timeout_pulse_next = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    gnt_next       = ~pick_mask;
                    owner_next     = pick_idx;
                    start_cnt_next = '0;
                    state_next     = GRANT;
                end
            end
            GRANT: begin
                if (!bus.iframe) begin
                    tenure_cnt_next = '0;
                    state_next      = BUSY;
                end else if (!owner_req) begin
                    gnt_next    = '1;
                    rr_ptr_next = wrap_inc(owner);
                    state_next  = IDLE;
                end else if (start_cnt == SW'(START_TIMEOUT - 1)) begin
                    gnt_next           = '1;
                    rr_ptr_next        = wrap_inc(owner);
                    timeout_pulse_next = 1'b1;
                    state_next         = IDLE;
                end else begin
                    start_cnt_next = start_cnt + 1'b1;
                end
            end
            BUSY: begin
                if (tenure_cnt != TW'(MAX_TENURE)) begin
                    tenure_cnt_next = tenure_cnt + 1'b1;
                end
                // Withdrawal and preemption share one exit; an idle bus with a
                // still-requesting owner keeps the grant for back-to-back cycles.
                if (!owner_req || (tenure_cnt >= TW'(MAX_TENURE - 1) && other_req)) begin
                    gnt_next    = '1;
                    rr_ptr_next = wrap_inc(owner);
                    state_next  = RELEASE;
                end
            end
            RELEASE: begin
                if (bus_idle) begin
                    state_next = IDLE;
                end
            end
            default: begin
                gnt_next   = '1;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            gnt           <= '1;
            owner         <= '0;
            rr_ptr        <= '0;
            start_cnt     <= '0;
            tenure_cnt    <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            state         <= state_next;
            gnt           <= gnt_next;
            owner         <= owner_next;
            rr_ptr        <= rr_ptr_next;
            start_cnt     <= start_cnt_next;
            tenure_cnt    <= tenure_cnt_next;
            timeout_pulse <= timeout_pulse_next;
        end
    end

    assign bus.gnt           = gnt;
    assign bus.owner         = owner;
    assign bus.bus_busy      = (state == BUSY) || (state == RELEASE);
    assign bus.timeout_pulse = timeout_pulse;
endmodule
